// File: rtl/fwft_pattern_source_if.sv
// Read-side bundle of the pattern source: the consumer's pop strobe and
// the FWFT head word with its empty and reset-busy flags.
interface fwft_pattern_source_if #(
   parameter int DW = 64
);
   logic          RD_I;
   logic [DW-1:0] RD_DATA_O;
   logic          RD_EMPTY_O;
   logic          RD_RST_BUSY_O;

   modport master (
      output RD_I,
      input  RD_DATA_O, RD_EMPTY_O, RD_RST_BUSY_O
   );

   modport slave (
      input  RD_I,
      output RD_DATA_O, RD_EMPTY_O, RD_RST_BUSY_O
   );
endinterface

// File: rtl/fwft_pattern_source.sv
// Frame-synchronous video pattern generator behind an FWFT read port;
// stands in for the scaler's input FIFO during bring-up and regressions.
module fwft_pattern_source #(
   parameter int C_PORT_NUM        = 4,
   parameter int C_BYTES_PER_PIXEL = 2,
   parameter int C_BUF_DEPTH       = 4,
   parameter int C_RST_BUSY_CYCLES = 8
) (
   input  logic                           AXI4_CLK_I,
   input  logic                           AXI4_RST_I,
   input  logic                           VS_I,
   input  logic [15:0]                    HACTIVE_I,
   input  logic [15:0]                    VACTIVE_I,
   input  logic [1:0]                     PATTERN_SEL_I,
   input  logic [8*C_BYTES_PER_PIXEL-1:0] COLOR_I,
   fwft_pattern_source_if.slave           rd_if,
   output logic                           FRAME_DONE_O,
   output logic [15:0]                    UNDERFLOW_CNT_O
);
   localparam int P            = 8 * C_BYTES_PER_PIXEL;
   localparam int C_DATA_WIDTH = C_PORT_NUM * P;
   localparam int HP           = P / 2;
   localparam int AW           = $clog2(C_BUF_DEPTH);
   localparam int CW           = AW + 1;
   localparam int FW           = $clog2(C_RST_BUSY_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FLUSH,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t                  state_q, state_d;
   logic                    vs_q, vs_prev_q;
   logic [FW-1:0]           flush_cnt_q, flush_cnt_d;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [C_DATA_WIDTH-1:0] mem_q [C_BUF_DEPTH];
   logic [C_DATA_WIDTH-1:0] mem_d [C_BUF_DEPTH];
   logic [15:0]             w_q, w_d;
   logic [15:0]             v_q, v_d;
   logic [1:0]              mode_q, mode_d;
   logic [15:0]             col_q, col_d;
   logic [15:0]             y_q, y_d;
   logic [15:0]             x_q, x_d;
   logic [P-1:0]            lin_q, lin_d;
   logic                    done_q, done_d;
   logic [15:0]             uf_q, uf_d;

   logic                    vs_edge;
   logic                    empty;
   logic                    pop;
   logic                    wr_en;
   logic                    last_word;
   logic                    line_end;
   logic [C_DATA_WIDTH-1:0] gen_word;
   logic [P-1:0]            pix;
   logic [HP-1:0]           xk;

   assign vs_edge   = vs_q & ~vs_prev_q;
   assign empty     = (cnt_q == '0);
   assign pop       = rd_if.RD_I & ~empty;
   assign line_end  = (col_q == w_q - 16'd1);
   assign last_word = line_end && (y_q == v_q - 16'd1);
   assign wr_en     = (state_q == S_RUN)
                    && ((cnt_q != CW'(C_BUF_DEPTH)) || pop);

   // Lane k of the current word carries pixel x = x_q + k.
   always_comb begin
      gen_word = '0;
      pix      = '0;
      xk       = '0;
      for (int k = 0; k < C_PORT_NUM; k++) begin
         xk = x_q[HP-1:0] + HP'(k);
         unique case (mode_q)
            2'd0:    pix = lin_q + P'(k);
            2'd1:    pix = {y_q[HP-1:0], xk};
            default: pix = COLOR_I;
         endcase
         gen_word[P*k +: P] = pix;
      end
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q + CW'(wr_en) - CW'(pop);
      mem_d       = mem_q;
      w_d         = w_q;
      v_d         = v_q;
      mode_d      = mode_q;
      col_d       = col_q;
      y_d         = y_q;
      x_d         = x_q;
      lin_d       = lin_q;
      done_d      = 1'b0;
      uf_d        = uf_q;

      if (rd_if.RD_I && empty && (uf_q != 16'hFFFF))
         uf_d = uf_q + 16'd1;

      if (pop)
         rd_ptr_d = rd_ptr_q + AW'(1);

      if (wr_en) begin
         mem_d[wr_ptr_q] = gen_word;
         wr_ptr_d        = wr_ptr_q + AW'(1);
         lin_d           = lin_q + P'(C_PORT_NUM);
         if (line_end) begin
            col_d = '0;
            x_d   = '0;
            y_d   = y_q + 16'd1;
         end else begin
            col_d = col_q + 16'd1;
            x_d   = x_q + 16'(C_PORT_NUM);
         end
      end

      unique case (state_q)
         S_FLUSH: begin
            flush_cnt_d = flush_cnt_q + FW'(1);
            if (flush_cnt_q == FW'(C_RST_BUSY_CYCLES - 1)) begin
               if ((w_q == '0) || (v_q == '0)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (wr_en && last_word)
               state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (pop && (cnt_q == CW'(1))) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: ;
      endcase

      // A new frame start overrides everything, discarding the old frame.
      if (vs_edge) begin
         state_d     = S_FLUSH;
         flush_cnt_d = '0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         cnt_d       = '0;
         w_d         = 16'(HACTIVE_I / 16'(C_PORT_NUM));
         v_d         = VACTIVE_I;
         mode_d      = PATTERN_SEL_I;
         col_d       = '0;
         y_d         = '0;
         x_d         = '0;
         lin_d       = '0;
         done_d      = 1'b0;
      end
   end

   always_ff @(posedge AXI4_CLK_I or posedge AXI4_RST_I) begin
      if (AXI4_RST_I) begin
         state_q     <= S_IDLE;
         vs_q        <= 1'b0;
         vs_prev_q   <= 1'b0;
         flush_cnt_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         for (int i = 0; i < C_BUF_DEPTH; i++)
            mem_q[i] <= '0;
         w_q         <= '0;
         v_q         <= '0;
         mode_q      <= '0;
         col_q       <= '0;
         y_q         <= '0;
         x_q         <= '0;
         lin_q       <= '0;
         done_q      <= 1'b0;
         uf_q        <= '0;
      end else begin
         state_q     <= state_d;
         vs_q        <= VS_I;
         vs_prev_q   <= vs_q;
         flush_cnt_q <= flush_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         mem_q       <= mem_d;
         w_q         <= w_d;
         v_q         <= v_d;
         mode_q      <= mode_d;
         col_q       <= col_d;
         y_q         <= y_d;
         x_q         <= x_d;
         lin_q       <= lin_d;
         done_q      <= done_d;
         uf_q        <= uf_d;
      end
   end

   assign rd_if.RD_DATA_O     = empty ? '0 : mem_q[rd_ptr_q];
   assign rd_if.RD_EMPTY_O    = empty;
   assign rd_if.RD_RST_BUSY_O = (state_q == S_FLUSH);
   assign FRAME_DONE_O        = done_q;
   assign UNDERFLOW_CNT_O     = uf_q;

endmodule

// File: tb/tb_fwft_pattern_source.sv
// Directed and randomized checks of the FWFT pattern source against a
// raster-order pattern model computed from frame geometry.
module tb_fwft_pattern_source;
   logic        clk = 1'b0;
   logic        rst;
   logic        vs;
   logic [15:0] hact;
   logic [15:0] vact;
   logic [1:0]  sel;
   logic [15:0] color;
   logic        frame_done;
   logic [15:0] uf;

   fwft_pattern_source_if #(.DW(64)) rd_if ();

   fwft_pattern_source dut (
      .AXI4_CLK_I      (clk),
      .AXI4_RST_I      (rst),
      .VS_I            (vs),
      .HACTIVE_I       (hact),
      .VACTIVE_I       (vact),
      .PATTERN_SEL_I   (sel),
      .COLOR_I         (color),
      .rd_if           (rd_if),
      .FRAME_DONE_O    (frame_done),
      .UNDERFLOW_CNT_O (uf)
   );

   always #5 clk = ~clk;

   int          nvec = 0;
   int          nerr = 0;
   int          m_h, m_v, m_mode;
   logic [15:0] m_color;
   int          idx, total;
   bit          exp_done;
   logic [15:0] exp_uf;
   bit          hold;
   logic [63:0] hold_data;
   logic [63:0] got [256];

   function automatic logic [63:0] exp_word(input int i);
      int          w, y, c, x;
      logic [15:0] px;
      logic [63:0] r;
      w = m_h / 4;
      y = i / w;
      c = i % w;
      r = '0;
      for (int k = 0; k < 4; k++) begin
         x = c * 4 + k;
         case (m_mode)
            0:       px = 16'((y * w * 4 + x) % 65536);
            1:       px = {8'(y % 256), 8'(x % 256)};
            default: px = m_color;
         endcase
         r[16*k +: 16] = px;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] o,
                      input logic [63:0] e);
      nvec++;
      assert (o === e) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   // Called at a negedge: check the visible head, drive RD_I, advance.
   task automatic cyc(input logic rd);
      logic        emp;
      logic [63:0] d;
      emp = rd_if.RD_EMPTY_O;
      d   = rd_if.RD_DATA_O;
      if (hold) begin
         chk("hold_empty", emp, 0);
         chk("hold_data", d, hold_data);
      end
      if (emp) chk("empty_data_zero", d, 0);
      rd_if.RD_I = rd;
      hold = 0;
      if (rd && !emp) begin
         chk("extra_pop", idx < total, 1);
         if (idx < total) begin
            chk($sformatf("word%0d", idx), d, exp_word(idx));
            if (idx < 256) got[idx] = d;
         end
         idx++;
         if (idx == total) exp_done = 1;
      end else if (!emp) begin
         hold      = 1;
         hold_data = d;
      end
      if (rd && emp && exp_uf != 16'hFFFF) exp_uf++;
      @(negedge clk);
      chk("frame_done", frame_done, exp_done);
      if (exp_done) chk("empty_at_done", rd_if.RD_EMPTY_O, 1);
      exp_done = 0;
      chk("underflow_cnt", uf, exp_uf);
   endtask

   // Raises VS for vs_len cycles and walks through the flush window,
   // ending at the negedge of cycle t+9 (busy just dropped).
   task automatic start_frame(input int h, input int v, input int mode,
                              input logic [15:0] col, input int vs_len,
                              input logic rd_pre, input logic rd_flush);
      hact  = 16'(h);
      vact  = 16'(v);
      sel   = 2'(mode);
      color = col;
      vs    = 1'b1;
      cyc(rd_pre);
      if (vs_len <= 1) vs = 1'b0;
      chk("busy_t", rd_if.RD_RST_BUSY_O, 0);
      cyc(rd_pre);
      m_h      = h;
      m_v      = v;
      m_mode   = mode;
      m_color  = col;
      idx      = 0;
      total    = (h / 4) * v;
      hold     = 0;
      exp_done = 0;
      for (int j = 1; j <= 8; j++) begin
         if (j + 1 >= vs_len) vs = 1'b0;
         chk("busy_flush", rd_if.RD_RST_BUSY_O, 1);
         chk("empty_flush", rd_if.RD_EMPTY_O, 1);
         if (j == 8 && total == 0) exp_done = 1;
         cyc(rd_flush);
      end
      chk("busy_end", rd_if.RD_RST_BUSY_O, 0);
      chk("empty_t9", rd_if.RD_EMPTY_O, 1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst        = 1'b1;
      vs         = 1'b0;
      hact       = '0;
      vact       = '0;
      sel        = '0;
      color      = '0;
      rd_if.RD_I = 1'b0;
      idx        = 0;
      total      = 0;
      exp_done   = 0;
      exp_uf     = '0;
      hold       = 0;
      m_h = 4; m_v = 0; m_mode = 0; m_color = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_data", rd_if.RD_DATA_O, 0);
      chk("rst_empty", rd_if.RD_EMPTY_O, 1);
      chk("rst_busy", rd_if.RD_RST_BUSY_O, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_uf", uf, 0);
      rst = 1'b0;
      cyc(0);

      // Mode 0 at full rate, RD_I high through flush and after the end
      start_frame(64, 16, 0, 16'h0, 1, 0, 1);
      cyc(0);
      chk("first_word_t10", rd_if.RD_EMPTY_O, 0);
      n = 0;
      while (idx < 256 && n < 400) begin
         cyc(1);
         n++;
      end
      chk("no_bubbles", n, 256);
      repeat (5) cyc(1);
      chk("uf13", uf, 13);
      chk("m0_word0", got[0], 64'h0003000200010000);
      chk("m0_word1", got[1], 64'h0007000600050004);
      chk("m0_word255", got[255], 64'h03FF03FE03FD03FC);

      // Mode 1 ramp, VS held two cycles
      start_frame(64, 16, 1, 16'h0, 2, 0, 0);
      cyc(0);
      n = 0;
      while (idx < 256 && n < 400) begin
         cyc(1);
         n++;
      end
      chk("m1_pops", idx, 256);
      chk("m1_word17", got[17], 64'h0107010601050104);
      chk("m1_word255", got[255], 64'h0F3F0F3E0F3D0F3C);
      cyc(0);

      // Constant colour with random pops, VS held three cycles
      start_frame(64, 16, 2, 16'hABCD, 3, 0, 0);
      n = 0;
      while (idx < 256 && n < 3000) begin
         cyc(1'($urandom % 2));
         n++;
      end
      repeat (10) cyc(1'($urandom % 2));
      chk("m2_pops", idx, 256);
      chk("m2_word", got[200], 64'hABCDABCDABCDABCD);

      // New VS after 100 pops discards the frame without FRAME_DONE_O
      start_frame(64, 16, 0, 16'h0, 1, 0, 0);
      cyc(0);
      n = 0;
      while (idx < 100 && n < 200) begin
         cyc(1);
         n++;
      end
      chk("abort_pops", idx, 100);
      start_frame(32, 4, 1, 16'h0, 1, 1, 0);
      cyc(0);
      chk("new_word0", rd_if.RD_DATA_O, exp_word(0));
      n = 0;
      while (idx < 32 && n < 500) begin
         cyc(1'($urandom % 2));
         n++;
      end
      chk("new_pops", idx, 32);
      cyc(0);

      // Zero-length frames: W = 0, then VACTIVE_I = 0
      start_frame(3, 5, 0, 16'h0, 1, 0, 0);
      repeat (4) cyc(1);
      chk("zero_w_empty", rd_if.RD_EMPTY_O, 1);
      start_frame(64, 0, 0, 16'h0, 1, 0, 0);
      repeat (3) cyc(0);

      // Asynchronous reset in the middle of a running frame
      start_frame(64, 16, 2, 16'h1234, 1, 0, 0);
      cyc(0);
      repeat (20) cyc(1);
      chk("pre_rst_empty", rd_if.RD_EMPTY_O, 0);
      rd_if.RD_I = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_empty", rd_if.RD_EMPTY_O, 1);
      chk("arst_data", rd_if.RD_DATA_O, 0);
      chk("arst_busy", rd_if.RD_RST_BUSY_O, 0);
      chk("arst_done", frame_done, 0);
      chk("arst_uf", uf, 0);
      @(negedge clk);
      rst    = 1'b0;
      exp_uf = '0;
      hold   = 0;
      idx    = 0;
      total  = 0;
      repeat (4) cyc(0);
      chk("post_rst_idle", rd_if.RD_EMPTY_O, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/fwft_pattern_source.md
# fwft_pattern_source

FWFT read-port responder that feeds the scaler's upstream read interface with a deterministic, frame-synchronous video pattern. It stands in for the AXI4-fed FIFO on the scaler's input side. It answers RD strobes exactly as a first-word-fall-through FIFO does, with empty and reset-busy flags. Used as a bring-up source and as the stimulus end in scaler regressions.

## Interface
- C_PORT_NUM, 4, pixels packed per data word
- C_BYTES_PER_PIXEL, 2, bytes per pixel; pixel width P = 8*C_BYTES_PER_PIXEL
- C_DATA_WIDTH, C_PORT_NUM*C_BYTES_PER_PIXEL*8 (64), derived, not overridden
- C_BUF_DEPTH, 4, internal prefetch buffer entries (power of 2, >=2)
- C_RST_BUSY_CYCLES, 8, cycles RD_RST_BUSY_O is held after each VS edge
- AXI4_CLK_I  in  1  sole clock
- AXI4_RST_I  in  1  asynchronous, active-high reset
- VS_I  in  1  frame start; rising edge is the event
- HACTIVE_I  in  16  pixels per line, latched at VS edge
- VACTIVE_I  in  16  lines per frame, latched at VS edge
- PATTERN_SEL_I  in  2  0 pixel index, 1 {y,x} ramp, 2/3 constant COLOR_I; latched at VS edge
- COLOR_I  in  P  constant pixel value for modes 2/3
- RD_I  in  1  read/pop strobe from consumer
- RD_DATA_O  out  C_DATA_WIDTH  head word (FWFT)
- RD_EMPTY_O  out  1  no valid head word
- RD_RST_BUSY_O  out  1  flush in progress
- FRAME_DONE_O  out  1  one-cycle pulse when last word of frame is popped
- UNDERFLOW_CNT_O  out  16  saturating count of RD_I while empty

## Operation
- Words per line W = floor(HACTIVE_I / C_PORT_NUM); frame length = W*VACTIVE_I words; word order raster, line 0 first.
- Lane k (bits [P*k+P-1 : P*k]) of a word at line y, word column c carries pixel x = c*C_PORT_NUM + k.
- Mode 0: pixel = (y*W*C_PORT_NUM + x) mod 2^P. Mode 1: pixel = ((y mod 2^(P/2)) << P/2) | (x mod 2^(P/2)). Modes 2/3: COLOR_I.
- FSM: IDLE -> (VS edge) FLUSH -> (C_RST_BUSY_CYCLES elapsed) RUN -> (last word generated) DRAIN -> (buffer empty after last pop) IDLE. Any VS edge in any state -> FLUSH.
- FLUSH: buffer cleared, x/y counters cleared, parameters latched, RD_RST_BUSY_O=1, RD_EMPTY_O=1.
- RUN: generator writes one word per cycle whenever buffer not full, or full with a pop in the same cycle.
- Pop occurs when RD_I=1 and RD_EMPTY_O=0; head advances next cycle.
- RD_I while RD_EMPTY_O=1 (including FLUSH/IDLE): no state change, UNDERFLOW_CNT_O += 1, saturating at 0xFFFF; cleared only by reset.
- Zero-length frame (W=0 or VACTIVE_I=0): FLUSH -> IDLE, FRAME_DONE_O pulses the cycle after busy drops, RD_EMPTY_O stays 1.
- RD_DATA_O = 0 whenever RD_EMPTY_O=1.

## Timing
- Reset values: RD_DATA_O=0, RD_EMPTY_O=1, RD_RST_BUSY_O=0, FRAME_DONE_O=0, UNDERFLOW_CNT_O=0; FSM IDLE.
- VS_I registered; edge = high in cycle t, low in t-1. RD_RST_BUSY_O high cycles t+1..t+C_RST_BUSY_CYCLES.
- First generated word written at t+C_RST_BUSY_CYCLES+1; RD_EMPTY_O=0 with word 0 at t+C_RST_BUSY_CYCLES+2.
- With RD_I held high from that point, one word popped per clock, no bubbles, until the frame ends.
- FRAME_DONE_O is high the cycle after the pop of the last word; RD_EMPTY_O=1 in that same cycle.
- VS edge mid-frame: the current frame is discarded with no FRAME_DONE_O; a pop in the edge cycle t still completes.
- VS held high for multiple cycles counts as one edge.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous), FSM IDLE.

## Test plan
- H=64, V=16, mode 0, RD_I=1 always, C_RST_BUSY_CYCLES=8 -> 256 words, word0=0x0003000200010000, word1=0x0007000600050004, word255=0x03FF03FE03FD03FC, FRAME_DONE_O one pulse, zero bubbles.
- Same frame, mode 1 -> word17 (y=1, x=4..7)=0x0107010601050104; word255=0x0F3F0F3E0F3D0F3C.
- Random RD_I (50% duty), mode 2, COLOR_I=0xABCD -> every word 0xABCDABCDABCDABCD, exactly 256 pops, data never changes while RD_I=0.
- RD_I=1 during FLUSH (8 cycles) and for 5 cycles after frame end -> UNDERFLOW_CNT_O=13; RD_RST_BUSY_O timing exactly t+1..t+8.
- Second VS edge after 100 pops -> no FRAME_DONE_O for the first frame; next word after busy is word0 of the new frame.
- HACTIVE_I=3 (W=0) -> RD_EMPTY_O stays 1, FRAME_DONE_O pulses at t+9; async reset mid-RUN -> RD_EMPTY_O=1 and RD_DATA_O=0 with no clock edge.
